// File: rtl/psum_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : psum_arb_pkg
// Purpose : Types and defaults shared by the GLB psum port arbiter and its
//           burst counter.
// Contents: owner_t          - current owner of the GLB psum port
//           BURST_MAX_DEFAULT - default limit on consecutive grants to one side
// Revision: 1.0  initial release
// ============================================================================
package psum_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_RD   = 2'd2
  } owner_t;

  localparam int BURST_MAX_DEFAULT = 16;

endpackage : psum_arb_pkg
`default_nettype wire

// File: rtl/glb_psum_port_arbiter_burst_counter.sv
`default_nettype none
// ============================================================================
// Module  : burst_counter
// Purpose : Saturating count of consecutive grants to the current owner.
// Ports   : clk     in  clock
//           reset   in  asynchronous active-low reset
//           clear   in  count <= 0              (highest priority)
//           load1   in  count <= 1              (owner change)
//           inc     in  count <= count + 1, holds at BURST_MAX
//           count   out current count
//           at_max  out count == BURST_MAX
// Revision: 1.0  initial release
// ============================================================================
module burst_counter
  import psum_arb_pkg::*;
#(
  parameter int BURST_MAX   = BURST_MAX_DEFAULT,
  parameter int BURST_WIDTH = $clog2(BURST_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load1,
  input  logic                   inc,
  output logic [BURST_WIDTH-1:0] count,
  output logic                   at_max
);

  localparam logic [BURST_WIDTH-1:0] LIMIT = BURST_WIDTH'(BURST_MAX);

  assign at_max = (count == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= BURST_WIDTH'(1);
    end else if (inc && !at_max) begin
      count <= count + BURST_WIDTH'(1);
    end
  end

endmodule : burst_counter
`default_nettype wire

// File: rtl/glb_psum_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : glb_psum_port_arbiter
// Purpose : Shares the single-port GLB psum bank between opsum writeback and
//           ipsum readback. Round-robin with bounded bursts; one access per
//           cycle with no bubble on owner switch. Read data returns with a
//           valid strobe one cycle after the read grant.
// Ports   : clk, reset (async, active-low)
//           wr_req/wr_addr/wr_data -> wr_gnt      opsum write side
//           rd_req/rd_addr         -> rd_gnt      ipsum read side
//           rd_valid/rd_data                      read return
//           glb_en/glb_we/glb_addr/glb_wdata/glb_rdata  GLB bank port
//           busy                                  port currently owned
// Revision: 1.0  initial release
// ============================================================================
module glb_psum_port_arbiter
  import psum_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int BURST_MAX   = BURST_MAX_DEFAULT,
  parameter int BURST_WIDTH = $clog2(BURST_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  glb_en,
  output logic                  glb_we,
  output logic [ADDR_WIDTH-1:0] glb_addr,
  output logic [DATA_WIDTH-1:0] glb_wdata,
  input  logic [DATA_WIDTH-1:0] glb_rdata,
  output logic                  busy
);

  owner_t                 owner;
  owner_t                 last;
  owner_t                 sel;
  logic [BURST_WIDTH-1:0] burst_cnt;
  logic                   at_max;
  logic                   cnt_clear;
  logic                   cnt_load1;
  logic                   cnt_inc;

  // Select is a function of registered owner/burst state and live requests.
  // Gating on reset keeps every grant and GLB strobe low while reset is held.
  always_comb begin
    sel = OWN_IDLE;
    if (reset) begin
      case (owner)
        OWN_WR: begin
          if (wr_req && !(rd_req && at_max)) sel = OWN_WR;
          else if (rd_req)                   sel = OWN_RD;
        end
        OWN_RD: begin
          if (rd_req && !(wr_req && at_max)) sel = OWN_RD;
          else if (wr_req)                   sel = OWN_WR;
        end
        default: begin
          // From idle a tie goes to the side that was not served last.
          if (wr_req && rd_req) sel = (last == OWN_RD) ? OWN_WR : OWN_RD;
          else if (wr_req)      sel = OWN_WR;
          else if (rd_req)      sel = OWN_RD;
        end
      endcase
    end
  end

  assign wr_gnt    = (sel == OWN_WR);
  assign rd_gnt    = (sel == OWN_RD);
  assign glb_en    = wr_gnt | rd_gnt;
  assign glb_we    = wr_gnt;
  assign glb_addr  = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : '0);
  assign glb_wdata = wr_gnt ? wr_data : '0;
  assign rd_data   = glb_rdata;
  assign busy      = (owner != OWN_IDLE);

  assign cnt_clear = (sel == OWN_IDLE);
  assign cnt_load1 = (sel != OWN_IDLE) && (sel != owner);
  assign cnt_inc   = (sel != OWN_IDLE) && (sel == owner);

  burst_counter #(
    .BURST_MAX   (BURST_MAX),
    .BURST_WIDTH (BURST_WIDTH)
  ) u_burst_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .load1  (cnt_load1),
    .inc    (cnt_inc),
    .count  (burst_cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= OWN_IDLE;
      last     <= OWN_RD;
      rd_valid <= 1'b0;
    end else begin
      owner    <= sel;
      if (sel != OWN_IDLE) last <= sel;
      rd_valid <= rd_gnt;
    end
  end

endmodule : glb_psum_port_arbiter
`default_nettype wire

// File: tb/tb_glb_psum_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_glb_psum_port_arbiter
// Purpose : Self-checking bench for glb_psum_port_arbiter. A behavioural
//           reference (streak length of the side last served, last-served
//           side, memory image) predicts grants, GLB drive and read returns.
//           A small GLB bank model answers the DUT's GLB port.
// Revision: 1.0  initial release
// ============================================================================
module tb_glb_psum_port_arbiter;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int BURST = 16;

  logic          clk;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          glb_en;
  logic          glb_we;
  logic [AW-1:0] glb_addr;
  logic [DW-1:0] glb_wdata;
  logic [DW-1:0] glb_rdata;
  logic          busy;

  glb_psum_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .glb_en    (glb_en),
    .glb_we    (glb_we),
    .glb_addr  (glb_addr),
    .glb_wdata (glb_wdata),
    .glb_rdata (glb_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB bank: 1-cycle read latency, answers whatever the DUT drives.
  logic [DW-1:0] glb_mem [0:1023] = '{default: 16'h0000};
  initial glb_rdata = '0;
  always @(posedge clk) begin
    if (glb_en && glb_we)  glb_mem[glb_addr[9:0]] <= glb_wdata;
    if (glb_en && !glb_we) glb_rdata <= glb_mem[glb_addr[9:0]];
  end

  // Reference: 0 = none, 1 = write side, 2 = read side.
  logic [DW-1:0] ref_mem [0:1023] = '{default: 16'h0000};
  int            m_prev;     // side granted in the previous cycle
  int            m_streak;   // how many cycles in a row that side was granted
  int            m_last;     // side granted most recently
  int            exp_sel;
  logic          exp_rv;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] d_wa, d_ra;
  logic [DW-1:0] d_wd;

  int n_pass  = 0;
  int n_total = 0;

  function automatic int model_sel(input logic w, input logic r);
    if (!w && !r) return 0;
    if (w && !r)  return 1;
    if (r && !w)  return 2;
    if (m_prev == 0) return (m_last == 2) ? 1 : 2;
    if (m_streak >= BURST) return 3 - m_prev;
    return m_prev;
  endfunction

  task automatic model_reset();
    m_prev   = 0;
    m_streak = 0;
    m_last   = 2;
    exp_rv   = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic r, input logic [AW-1:0] ra);
    wr_req  = w;  wr_addr = wa; wr_data = wd;
    rd_req  = r;  rd_addr = ra;
    d_wa = wa; d_wd = wd; d_ra = ra;
    exp_sel = model_sel(w, r);
  endtask

  // Advance the reference by one cycle and move to just after the next edge.
  task automatic commit();
    if (exp_sel == 0) begin
      m_prev   = 0;
      m_streak = 0;
    end else begin
      if (exp_sel == m_prev) begin
        if (m_streak < BURST) m_streak++;
      end else begin
        m_prev   = exp_sel;
        m_streak = 1;
      end
      m_last = exp_sel;
    end
    if (exp_sel == 1) ref_mem[d_wa[9:0]] = d_wd;
    exp_rv = (exp_sel == 2);
    if (exp_sel == 2) exp_rdata = ref_mem[d_ra[9:0]];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 20'h00011, 16'h1111, 1'b1, 20'h00022);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({wr_gnt, rd_gnt, glb_en, glb_we, rd_valid, busy} !== 6'b0 || glb_addr !== '0 || glb_wdata !== '0) begin
        $display("FAIL reset_hold: gnt/en/we/rv/busy=%b addr=%h wdata=%h required all zero",
                 {wr_gnt, rd_gnt, glb_en, glb_we, rd_valid, busy}, glb_addr, glb_wdata);
      end else n_pass++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    drive(1'b1, 20'h00011, 16'h1111, 1'b1, 20'h00022);
    @(negedge clk);
    n_total++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0) begin
      $display("FAIL reset_first_grant: wr_gnt=%b rd_gnt=%b required 1 0", wr_gnt, rd_gnt);
    end else n_pass++;
    commit();
  endtask

  task automatic test_write_only();
    logic [DW-1:0] wd;
    drive(1'b0, '0, '0, 1'b0, '0);
    commit();
    for (int i = 0; i < 40; i++) begin
      wd = DW'($urandom);
      drive(1'b1, AW'(i), wd, 1'b0, '0);
      @(negedge clk);
      n_total++;
      if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || glb_en !== 1'b1 || glb_we !== 1'b1 ||
          glb_addr !== AW'(i) || glb_wdata !== wd) begin
        $display("FAIL write_only[%0d]: wg=%b rg=%b en=%b we=%b addr=%h wdata=%h required 1 0 1 1 %h %h",
                 i, wr_gnt, rd_gnt, glb_en, glb_we, glb_addr, glb_wdata, AW'(i), wd);
      end else n_pass++;
      commit();
    end
  endtask

  task automatic test_contention();
    int first;
    int want;
    logic prev_rd;
    drive(1'b0, '0, '0, 1'b0, '0);
    commit();
    first   = (m_last == 2) ? 1 : 2;
    prev_rd = 1'b0;
    for (int i = 0; i < 64; i++) begin
      want = (((i / BURST) % 2) == 0) ? first : 3 - first;
      drive(1'b1, AW'($urandom_range(0, 63)), DW'($urandom), 1'b1, AW'($urandom_range(0, 63)));
      @(negedge clk);
      n_total++;
      if (wr_gnt !== (want == 1) || rd_gnt !== (want == 2) || want != exp_sel) begin
        $display("FAIL contention[%0d]: wg=%b rg=%b required side %0d", i, wr_gnt, rd_gnt, want);
      end else n_pass++;
      n_total++;
      if (rd_valid !== prev_rd || (prev_rd && rd_data !== exp_rdata)) begin
        $display("FAIL contention_rv[%0d]: rd_valid=%b rd_data=%h required %b %h",
                 i, rd_valid, rd_data, prev_rd, exp_rdata);
      end else n_pass++;
      prev_rd = (want == 2);
      commit();
    end
  endtask

  task automatic test_raw();
    drive(1'b0, '0, '0, 1'b0, '0);
    commit();
    drive(1'b1, 20'd5, 16'hBEEF, 1'b0, '0);
    @(negedge clk);
    n_total++;
    if (wr_gnt !== 1'b1 || glb_addr !== 20'd5 || glb_wdata !== 16'hBEEF) begin
      $display("FAIL raw_write: wr_gnt=%b addr=%h wdata=%h required 1 00005 beef", wr_gnt, glb_addr, glb_wdata);
    end else n_pass++;
    commit();
    drive(1'b0, '0, '0, 1'b1, 20'd5);
    @(negedge clk);
    n_total++;
    if (rd_gnt !== 1'b1 || glb_we !== 1'b0 || glb_addr !== 20'd5 || glb_wdata !== '0) begin
      $display("FAIL raw_read: rd_gnt=%b we=%b addr=%h wdata=%h required 1 0 00005 0000",
               rd_gnt, glb_we, glb_addr, glb_wdata);
    end else n_pass++;
    commit();
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    n_total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
      $display("FAIL raw_data: rd_valid=%b rd_data=%h required 1 beef", rd_valid, rd_data);
    end else n_pass++;
    commit();
  endtask

  task automatic test_tie_rotation();
    int want;
    drive(1'b0, '0, '0, 1'b0, '0);
    commit();
    want = (m_last == 2) ? 1 : 2;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, AW'(100 + k), DW'($urandom), 1'b1, AW'(100 + k));
      @(negedge clk);
      n_total++;
      if (wr_gnt !== (want == 1) || rd_gnt !== (want == 2)) begin
        $display("FAIL tie_rotation[%0d]: wg=%b rg=%b required side %0d", k, wr_gnt, rd_gnt, want);
      end else n_pass++;
      commit();
      drive(1'b0, '0, '0, 1'b0, '0);
      commit();
      want = 3 - want;
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, '0, '0, 1'b1, 20'd7);
    @(negedge clk);
    n_total++;
    if (rd_gnt !== 1'b1) begin
      $display("FAIL midreset_rd_gnt: rd_gnt=%b required 1", rd_gnt);
    end else n_pass++;
    commit();
    reset = 1'b0;
    drive(1'b1, 20'd8, 16'h1234, 1'b1, 20'd7);
    #1;
    n_total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
      $display("FAIL midreset_drop: rd_valid=%b busy=%b rg=%b wg=%b required 0 0 0 0",
               rd_valid, busy, rd_gnt, wr_gnt);
    end else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    drive(1'b1, 20'd8, 16'h1234, 1'b1, 20'd7);
    @(negedge clk);
    n_total++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || rd_valid !== 1'b0) begin
      $display("FAIL midreset_first: wg=%b rg=%b rv=%b required 1 0 0", wr_gnt, rd_gnt, rd_valid);
    end else n_pass++;
    commit();
  endtask

  task automatic test_random();
    logic w, r;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      drive(w, AW'($urandom_range(0, 63)), DW'($urandom), r, AW'($urandom_range(0, 63)));
      ea = (exp_sel == 1) ? d_wa : ((exp_sel == 2) ? d_ra : '0);
      ed = (exp_sel == 1) ? d_wd : '0;
      @(negedge clk);
      n_total++;
      if (wr_gnt !== (exp_sel == 1) || rd_gnt !== (exp_sel == 2) ||
          glb_en !== (exp_sel != 0) || glb_we !== (exp_sel == 1)) begin
        $display("FAIL random_gnt[%0d]: wg=%b rg=%b en=%b we=%b required side %0d",
                 i, wr_gnt, rd_gnt, glb_en, glb_we, exp_sel);
      end else n_pass++;
      n_total++;
      if (glb_addr !== ea || glb_wdata !== ed) begin
        $display("FAIL random_glb[%0d]: addr=%h wdata=%h required %h %h", i, glb_addr, glb_wdata, ea, ed);
      end else n_pass++;
      n_total++;
      if (rd_valid !== exp_rv || (exp_rv && rd_data !== exp_rdata)) begin
        $display("FAIL random_rd[%0d]: rv=%b data=%h required %b %h", i, rd_valid, rd_data, exp_rv, exp_rdata);
      end else n_pass++;
      n_total++;
      if (busy !== (m_prev != 0)) begin
        $display("FAIL random_busy[%0d]: busy=%b required %b", i, busy, (m_prev != 0));
      end else n_pass++;
      commit();
    end
  endtask

  initial begin
    reset   = 1'b0;
    wr_req  = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req  = 1'b0; rd_addr = '0;
    model_reset();
    exp_rdata = '0;
    test_reset();
    test_write_only();
    test_contention();
    test_raw();
    test_tie_rotation();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_glb_psum_port_arbiter
`default_nettype wire
